// File: rtl/adc_scan_sequencer_if.sv
// rtl/adc_scan_sequencer_if.sv - ADC_INT command/response stream bundle between sequencer and ADC
interface adc_scan_sequencer_if #(
    parameter int CH_W   = 5,
    parameter int DATA_W = 12
);
    logic              command_valid;
    logic [CH_W-1:0]   command_channel;
    logic              command_startofpacket;
    logic              command_endofpacket;
    logic              command_ready;
    logic              response_valid;
    logic [CH_W-1:0]   response_channel;
    logic [DATA_W-1:0] response_data;

    modport master (
        output command_valid, command_channel, command_startofpacket, command_endofpacket,
        input  command_ready, response_valid, response_channel, response_data
    );

    modport slave (
        input  command_valid, command_channel, command_startofpacket, command_endofpacket,
        output command_ready, response_valid, response_channel, response_data
    );
endinterface

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - ADC slot-table scan sequencer; ADC_SCAN_AVG_EN enables 4x averaging per slot
module adc_scan_sequencer #(
    parameter int NUM_SLOTS = 8,
    parameter int CH_W      = 5,
    parameter int DATA_W    = 12,
    parameter int TIMEOUT   = 1023,
    localparam int SW       = $clog2(NUM_SLOTS)
) (
    input  logic                 clock_clk,
    input  logic                 reset_sink_reset_n,
    input  logic                 scan_en,
    input  logic [NUM_SLOTS-1:0] slot_en,
    input  logic                 cfg_wr,
    input  logic [SW-1:0]        cfg_slot,
    input  logic [CH_W-1:0]      cfg_chan,
    adc_scan_sequencer_if.master adc,
    output logic                 res_valid,
    output logic [SW-1:0]        res_slot,
    output logic [DATA_W-1:0]    res_data,
    output logic                 scan_done,
    output logic                 busy,
    output logic                 err_timeout,
    output logic                 err_mismatch
);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_CMD,
        S_WAIT_RSP,
        S_DONE
    } state_t;

    state_t            state, state_nxt;
    logic [CH_W-1:0]   chan_table [NUM_SLOTS];
    logic [SW-1:0]     ptr;
    logic              first;
    logic              last;
    logic [CH_W-1:0]   cur_chan;
    logic [TW-1:0]     timer;
    logic              scan_en_q;

    logic              sel_found;
    logic              sel_more;
    logic [SW-1:0]     sel_idx;
    logic              cmd_hs;
    logic              rsp_hit;
    logic              tmo_hit;
    logic              conv_last;

`ifdef ADC_SCAN_AVG_EN
    logic [1:0]        rep;
    logic [DATA_W+1:0] acc;
    logic [DATA_W+1:0] acc_sum;

    assign conv_last = (rep == 2'd3);
    assign acc_sum   = acc + {2'b00, adc.response_data};
`else
    assign conv_last = 1'b1;
`endif

    assign cmd_hs  = (state == S_CMD) && adc.command_ready;
    assign rsp_hit = (state == S_WAIT_RSP) && adc.response_valid;
    assign tmo_hit = (state == S_WAIT_RSP) && !adc.response_valid && (timer == TW'(TIMEOUT));

    // Lowest enabled slot at or above ptr, and whether any enabled slot lies beyond it
    always_comb begin
        sel_found = 1'b0;
        sel_more  = 1'b0;
        sel_idx   = ptr;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (slot_en[i] && (SW'(i) >= ptr)) begin
                if (!sel_found) begin
                    sel_found = 1'b1;
                    sel_idx   = SW'(i);
                end else begin
                    sel_more = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:     if (scan_en && (|slot_en)) state_nxt = S_SELECT;
            S_SELECT:   state_nxt = sel_found ? S_CMD : S_DONE;
            S_CMD:      if (cmd_hs) state_nxt = S_WAIT_RSP;
            S_WAIT_RSP: begin
                if (rsp_hit) begin
                    if (!conv_last)  state_nxt = S_CMD;
                    else             state_nxt = last ? S_DONE : S_SELECT;
                end else if (tmo_hit) begin
                    state_nxt = last ? S_DONE : S_SELECT;
                end
            end
            S_DONE:     state_nxt = scan_en ? S_SELECT : S_IDLE;
            default:    state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        adc.command_valid         = 1'b0;
        adc.command_channel       = '0;
        adc.command_startofpacket = 1'b0;
        adc.command_endofpacket   = 1'b0;
        if (state == S_CMD) begin
            adc.command_valid         = 1'b1;
            adc.command_channel       = cur_chan;
            adc.command_startofpacket = first;
            adc.command_endofpacket   = last && conv_last;
        end
        scan_done = (state == S_DONE);
        busy      = (state != S_IDLE);
    end

    always_ff @(posedge clock_clk or negedge reset_sink_reset_n) begin
        if (!reset_sink_reset_n) begin
            state        <= S_IDLE;
            ptr          <= '0;
            first        <= 1'b0;
            last         <= 1'b0;
            cur_chan     <= '0;
            timer        <= '0;
            scan_en_q    <= 1'b0;
            res_valid    <= 1'b0;
            res_slot     <= '0;
            res_data     <= '0;
            err_timeout  <= 1'b0;
            err_mismatch <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                chan_table[i] <= CH_W'(i);
            end
`ifdef ADC_SCAN_AVG_EN
            rep          <= '0;
            acc          <= '0;
`endif
        end else begin
            state     <= state_nxt;
            scan_en_q <= scan_en;
            res_valid <= 1'b0;
            if (cfg_wr) begin
                chan_table[cfg_slot] <= cfg_chan;
            end
            // Clear precedes the case so a timeout in the same cycle still sets the flag
            if (scan_en && !scan_en_q) begin
                err_timeout <= 1'b0;
            end
            case (state)
                S_IDLE: begin
                    if (state_nxt == S_SELECT) begin
                        ptr   <= '0;
                        first <= 1'b1;
                    end
                end
                S_SELECT: begin
                    if (sel_found) begin
                        ptr      <= sel_idx;
                        last     <= !sel_more;
                        cur_chan <= chan_table[sel_idx];
`ifdef ADC_SCAN_AVG_EN
                        rep      <= '0;
                        acc      <= '0;
`endif
                    end
                end
                S_CMD: begin
                    if (cmd_hs) begin
                        first <= 1'b0;
                        timer <= '0;
                    end
                end
                S_WAIT_RSP: begin
                    timer <= timer + 1'b1;
                    if (rsp_hit) begin
                        if (adc.response_channel != cur_chan) begin
                            err_mismatch <= 1'b1;
                        end
`ifdef ADC_SCAN_AVG_EN
                        acc <= acc_sum;
                        if (conv_last) begin
                            res_valid <= 1'b1;
                            res_slot  <= ptr;
                            res_data  <= acc_sum[DATA_W+1:2];
                            ptr       <= ptr + 1'b1;
                        end else begin
                            rep <= rep + 1'b1;
                        end
`else
                        res_valid <= 1'b1;
                        res_slot  <= ptr;
                        res_data  <= adc.response_data;
                        ptr       <= ptr + 1'b1;
`endif
                    end else if (tmo_hit) begin
                        err_timeout <= 1'b1;
                        ptr         <= ptr + 1'b1;
                    end
                end
                S_DONE: begin
                    if (scan_en) begin
                        ptr   <= '0;
                        first <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
